// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the combinational ALU: registers operands, waits a
// per-op latency, captures result and flags, and returns them on a valid/ready channel.
module alu_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [2:0]       req_op_i,
  input  logic [4:0]       req_shamt_i,
  input  logic             req_dir_i,
  input  logic             req_shift_i,
  input  logic [3:0]       req_tag_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_op_o,
  output logic [4:0]       alu_shift_amt_o,
  output logic             alu_dir_o,
  output logic             alu_shift_or_not_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_carry_i,
  input  logic             alu_overflow_i,
  input  logic             alu_zero_i,
  input  logic             alu_parity_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic [3:0]       rsp_flags_o,
  output logic [3:0]       rsp_tag_o,
  output logic             rsp_divzero_o,
  output logic [3:0]       status_flags_o,
  output logic             sticky_ovf_o,
  input  logic             sticky_clr_i,
  output logic [15:0]      op_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] MULDIV_LAT = 4'(MULDIV_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       lat_cnt_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic [4:0]       alu_shamt_q;
  logic             alu_dir_q, alu_shift_q;
  logic [3:0]       tag_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q, rsp_tag_q, status_flags_q;
  logic             rsp_divzero_q, sticky_ovf_q;
  logic [15:0]      op_count_q;

  logic [3:0]       lat_init_d;
  logic             capture_s;
  logic             divzero_d;
  logic             sticky_ovf_d;
  logic [3:0]       alu_flags_s;

  // Next-state helpers: initial latency, capture strobe, div-by-zero and sticky overflow.
  always_comb begin
    lat_init_d   = 4'd0;
    capture_s    = 1'b0;
    divzero_d    = 1'b0;
    sticky_ovf_d = sticky_ovf_q;
    alu_flags_s  = {alu_carry_i, alu_overflow_i, alu_zero_i, alu_parity_i};
    // A shift is always single-cycle even when the opcode field says MUL/DIV.
    if (!req_shift_i && (req_op_i == 3'b010 || req_op_i == 3'b011)) begin
      lat_init_d = MULDIV_LAT;
    end else begin
      lat_init_d = 4'd0;
    end
    if (state_q == S_EXEC && lat_cnt_q == 4'd0) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
    if (!alu_shift_q && alu_op_q == 3'b011 && alu_b_q == {WIDTH{1'b0}}) begin
      divzero_d = 1'b1;
    end else begin
      divzero_d = 1'b0;
    end
    if (capture_s && alu_overflow_i) begin
      sticky_ovf_d = 1'b1;
    end else if (sticky_clr_i) begin
      sticky_ovf_d = 1'b0;
    end else begin
      sticky_ovf_d = sticky_ovf_q;
    end
  end

  // Control FSM with registered ALU operands, response and status state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      lat_cnt_q      <= 4'd0;
      alu_a_q        <= {WIDTH{1'b0}};
      alu_b_q        <= {WIDTH{1'b0}};
      alu_op_q       <= 3'd0;
      alu_shamt_q    <= 5'd0;
      alu_dir_q      <= 1'b0;
      alu_shift_q    <= 1'b0;
      tag_q          <= 4'd0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= {WIDTH{1'b0}};
      rsp_flags_q    <= 4'd0;
      rsp_tag_q      <= 4'd0;
      rsp_divzero_q  <= 1'b0;
      status_flags_q <= 4'd0;
      sticky_ovf_q   <= 1'b0;
      op_count_q     <= 16'd0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            alu_a_q     <= req_a_i;
            alu_b_q     <= req_b_i;
            alu_op_q    <= req_op_i;
            alu_shamt_q <= req_shamt_i;
            alu_dir_q   <= req_dir_i;
            alu_shift_q <= req_shift_i;
            tag_q       <= req_tag_i;
            lat_cnt_q   <= lat_init_d;
            state_q     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (lat_cnt_q != 4'd0) begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end else begin
            rsp_result_q   <= alu_result_i;
            rsp_flags_q    <= alu_flags_s;
            rsp_tag_q      <= tag_q;
            rsp_divzero_q  <= divzero_d;
            status_flags_q <= alu_flags_s;
            rsp_valid_q    <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 16'd1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o        = (state_q == S_IDLE) && !rst_i;
  assign alu_a_o            = alu_a_q;
  assign alu_b_o            = alu_b_q;
  assign alu_op_o           = alu_op_q;
  assign alu_shift_amt_o    = alu_shamt_q;
  assign alu_dir_o          = alu_dir_q;
  assign alu_shift_or_not_o = alu_shift_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_result_o       = rsp_result_q;
  assign rsp_flags_o        = rsp_flags_q;
  assign rsp_tag_o          = rsp_tag_q;
  assign rsp_divzero_o      = rsp_divzero_q;
  assign status_flags_o     = status_flags_q;
  assign sticky_ovf_o       = sticky_ovf_q;
  assign op_count_o         = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU closes the loop, expected
// responses are queued at issue time and compared when the response handshake occurs.
module tb_alu_issue_ctrl;

  localparam int MULDIV = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_op;
  logic [4:0]  req_shamt;
  logic        req_dir, req_shift;
  logic [3:0]  req_tag;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic        alu_dir, alu_shift;
  logic        alu_carry, alu_ovf, alu_zero, alu_parity;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags, rsp_tag, status_flags;
  logic        rsp_divzero, sticky_ovf, sticky_clr;
  logic [15:0] op_count;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        divz;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] last_res;
  logic        last_divz;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .MULDIV_CYCLES(MULDIV)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .req_shamt_i(req_shamt), .req_dir_i(req_dir), .req_shift_i(req_shift),
    .req_tag_i(req_tag),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_shift_amt_o(alu_shamt), .alu_dir_o(alu_dir), .alu_shift_or_not_o(alu_shift),
    .alu_result_i(alu_result), .alu_carry_i(alu_carry), .alu_overflow_i(alu_ovf),
    .alu_zero_i(alu_zero), .alu_parity_i(alu_parity),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_flags_o(rsp_flags), .rsp_tag_o(rsp_tag), .rsp_divzero_o(rsp_divzero),
    .status_flags_o(status_flags), .sticky_ovf_o(sticky_ovf), .sticky_clr_i(sticky_clr),
    .op_count_o(op_count)
  );

  // Behavioural ALU: returns {carry, overflow, zero, parity, result}.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic [4:0] sh,
                                         input logic dir, input logic shf);
    logic [32:0] t;
    logic [63:0] p;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; r = 32'd0; t = 33'd0; p = 64'd0;
    if (shf) begin
      r = dir ? (b >> sh) : (b << sh);
    end else begin
      case (op)
        3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32];
                    v = (a[31] == b[31]) && (r[31] != a[31]); end
        3'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[31:0]; c = t[32];
                    v = (a[31] != b[31]) && (r[31] != a[31]); end
        3'd2: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; c = |p[63:32]; end
        3'd3: r = (b == 32'd0) ? 32'd0 : a / b;
        3'd4: r = a & b;
        3'd5: r = a | b;
        3'd6: r = a ^ b;
        default: r = 32'd0;
      endcase
    end
    return {c, v, (r == 32'd0), ~^r, r};
  endfunction

  assign {alu_carry, alu_ovf, alu_zero, alu_parity, alu_result} =
      alu_fn(alu_a, alu_b, alu_op, alu_shamt, alu_dir, alu_shift);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare each response at the moment it is handshaken.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready && !rst) begin
      if (sb_q.size() == 0) begin
        check_val("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check_val("rsp_result", rsp_result, x.res);
        check_val("rsp_flags", rsp_flags, x.flags);
        check_val("rsp_tag", rsp_tag, x.tag);
        check_val("rsp_divzero", rsp_divzero, x.divz);
        check_val("status_flags", status_flags, x.flags);
        last_res  = rsp_result;
        last_divz = rsp_divzero;
      end
    end
  end

  function automatic int lat_of(input logic [2:0] op, input logic shf);
    return (!shf && (op == 3'd2 || op == 3'd3)) ? MULDIV : 1;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [4:0] sh, input logic dir, input logic shf,
                       input logic [3:0] tag, input bit pulse_clr);
    int n;
    logic [35:0] e;
    exp_t x;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check_val("req_ready", req_ready, 1);
    req_a = a; req_b = b; req_op = op; req_shamt = sh; req_dir = dir;
    req_shift = shf; req_tag = tag; req_valid = 1'b1;
    e = alu_fn(a, b, op, sh, dir, shf);
    x.tag = tag; x.res = e[31:0]; x.flags = e[35:32];
    x.divz = !shf && (op == 3'd3) && (b == 32'd0);
    sb_q.push_back(x);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (pulse_clr) sticky_clr = 1'b1;
    n = 1;
    while (!rsp_valid && n < 40) begin
      check_val("alu_a_hold", alu_a, a);
      check_val("alu_op_hold", alu_op, op);
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      n++;
    end
    sticky_clr = 1'b0;
    check_val("latency", n, lat_of(op, shf) + 1);
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; sticky_clr = 1'b0;
    req_a = 32'd0; req_b = 32'd0; req_op = 3'd0; req_shamt = 5'd0;
    req_dir = 1'b0; req_shift = 1'b0; req_tag = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready", req_ready, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_op_count", op_count, 0);
    check_val("rst_alu_a", alu_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("idle_req_ready", req_ready, 1);

    // ADD overflow
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 5'd0, 1'b0, 1'b0, 4'd3, 1'b0);
    check_val("add_result", last_res, 32'h8000_0000);
    check_val("add_status", status_flags, 4'b0100);
    check_val("add_sticky", sticky_ovf, 1);
    check_val("add_count", op_count, 1);

    // MUL with carry-out
    do_op(32'h0001_0000, 32'h0001_0000, 3'd2, 5'd0, 1'b0, 1'b0, 4'd5, 1'b0);
    check_val("mul_status", status_flags, 4'b1011);

    // DIV by zero, then ordinary DIV
    do_op(32'd100, 32'd0, 3'd3, 5'd0, 1'b0, 1'b0, 4'd6, 1'b0);
    check_val("div0_divz", last_divz, 1);
    check_val("div0_status", status_flags, 4'b0011);
    do_op(32'd100, 32'd7, 3'd3, 5'd0, 1'b0, 1'b0, 4'd7, 1'b0);
    check_val("div_result", last_res, 32'd14);
    check_val("div_divz", last_divz, 0);

    // Shift carrying a DIV opcode
    do_op(32'd0, 32'h1, 3'd3, 5'd4, 1'b0, 1'b1, 4'd8, 1'b0);
    check_val("shift_result", last_res, 32'h10);
    check_val("shift_divz", last_divz, 0);

    for (int i = 0; i < 8; i++) begin
      do_op($urandom, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i), 1'b0);
    end
    check_val("count_after_rand", op_count, 13);

    // Backpressure with a competing request held in RESP
    rsp_ready = 1'b0;
    do_op(32'd9, 32'd3, 3'd6, 5'd0, 1'b0, 1'b0, 4'd9, 1'b0);
    req_a = 32'hDEAD_BEEF; req_b = 32'd1; req_op = 3'd0; req_shift = 1'b0;
    req_tag = 4'd10; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_rsp_valid", rsp_valid, 1);
      check_val("bp_req_ready", req_ready, 0);
      check_val("bp_rsp_result", rsp_result, 32'd10);
      check_val("bp_alu_a", alu_a, 32'd9);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_after_ready", req_ready, 1);
    check_val("bp_not_taken", alu_a, 32'd9);
    do_op(32'hDEAD_BEEF, 32'd1, 3'd0, 5'd0, 1'b0, 1'b0, 4'd10, 1'b0);
    check_val("bp_count", op_count, 15);

    // Reset in the middle of a MUL
    req_a = 32'd3; req_b = 32'd4; req_op = 3'd2; req_shift = 1'b0; req_tag = 4'd11;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mrst_rsp_valid", rsp_valid, 0);
    check_val("mrst_req_ready", req_ready, 0);
    check_val("mrst_alu_a", alu_a, 0);
    check_val("mrst_alu_b", alu_b, 0);
    check_val("mrst_alu_op", alu_op, 0);
    check_val("mrst_rsp_result", rsp_result, 0);
    check_val("mrst_rsp_flags", rsp_flags, 0);
    check_val("mrst_rsp_tag", rsp_tag, 0);
    check_val("mrst_status", status_flags, 0);
    check_val("mrst_sticky", sticky_ovf, 0);
    check_val("mrst_count", op_count, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check_val("mrst_no_rsp", seen, 0);

    // Overflow capture coincides with sticky_clr: set wins
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 5'd0, 1'b0, 1'b0, 4'd12, 1'b1);
    check_val("sticky_set_wins", sticky_ovf, 1);
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    check_val("sticky_cleared", sticky_ovf, 0);
    check_val("final_count", op_count, 1);
    check_val("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front-end and writeback controller for the combinational ALU. It accepts operation requests over a valid/ready handshake and registers the operands onto the ALU input ports. It holds them stable for a per-operation number of cycles, then captures result and flags and returns them over a valid/ready response channel. It also keeps architectural status state: last committed flags, sticky overflow and an operation counter.

## Interface
- WIDTH, 32, datapath width; must match the ALU.
- MULDIV_CYCLES, 4, cycles operands are held for MUL (3'b010) and DIV (3'b011) when not shifting; legal range 1..15.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_a, req_b  in  WIDTH  operands.
- req_op  in  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 nop.
- req_shamt  in  5  shift amount.
- req_dir  in  1  0 = left shift, 1 = right shift.
- req_shift  in  1  1 selects shift operation.
- req_tag  in  4  opaque ID, returned with the response.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_op  out  3  registered opcode.
- alu_shift_amt  out  5  registered shift amount.
- alu_dir  out  1  registered direction.
- alu_shift_or_not  out  1  registered shift select.
- alu_result  in  WIDTH  ALU result.
- alu_carry, alu_overflow, alu_zero, alu_parity  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  4  {carry, overflow, zero, parity}.
- rsp_tag  out  4  tag of the completed request.
- rsp_divzero  out  1  DIV with operand b == 0.
- status_flags  out  4  flags of the most recently captured operation.
- sticky_ovf  out  1  set by any captured overflow.
- sticky_clr  in  1  clears sticky_ovf.
- op_count  out  16  completed response handshakes, modulo 2^16.

## Operation
- FSM states:
  - IDLE: req_ready = 1 and not rst.
  - EXEC: ALU operands held stable.
  - RESP: rsp_valid = 1.
- IDLE: on req_valid and req_ready, latch all req_* fields into the alu_* registers and the tag register. Load lat_cnt = L-1 and go to EXEC.
- L (latency) = MULDIV_CYCLES if req_shift = 0 and req_op is 010 or 011; otherwise L = 1. Shifts always take 1 cycle, regardless of req_op.
- EXEC: if lat_cnt != 0, decrement it. If lat_cnt = 0:
  - capture alu_result and flags into the rsp_* registers and status_flags;
  - rsp_divzero = (alu_shift_or_not = 0, alu_op = 011, alu_b = 0);
  - go to RESP.
- RESP: hold all rsp_* outputs stable until rsp_ready. On rsp_valid and rsp_ready, increment op_count and return to IDLE.
- alu_* outputs change only on request acceptance and keep their last values in IDLE and RESP.
- sticky_ovf: set when captured overflow = 1; cleared by sticky_clr. If set and clear occur in the same cycle, set wins.
- op_count wraps from 0xFFFF to 0x0000.
- Requests presented outside IDLE are ignored; req_ready = 0 outside IDLE.
- The controller performs no arithmetic. Flags pass through exactly as the ALU produced them, including DIV-by-zero (result 0, zero = 1, parity = 1).

## Timing
- Accept at the end of cycle 0. EXEC occupies cycles 1..L. rsp_valid is first high in cycle L+1.
- With rsp_ready held high: req_ready is high again in cycle L+2, so sustained throughput is one op per L+2 cycles.
- status_flags and sticky_ovf update at the same edge where rsp_valid rises.
- Reset (rst high at an edge), from any state including mid-EXEC or RESP:
  - state = IDLE;
  - rsp_valid, req_ready (while rst = 1), all alu_*, rsp_result, rsp_flags, rsp_tag, rsp_divzero, status_flags, sticky_ovf and op_count = 0;
  - the in-flight operation is dropped with no response.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, tag 3, rsp_ready = 1 → rsp_valid in cycle 2; result 0x80000000; flags {0,1,0,0}; sticky_ovf = 1; op_count = 1.
- MUL 0x00010000 × 0x00010000, MULDIV_CYCLES = 4 → alu_* stable in cycles 1-4; rsp_valid in cycle 5; result 0; flags {1,0,1,1}.
- DIV 100 / 0 → rsp_divzero = 1, result 0, zero = 1. Next, DIV 100 / 7 → result 14, rsp_divzero = 0.
- Shift with req_op = 011, req_shift = 1, b = 0x1, shamt = 4, dir = 0 → L = 1; rsp_divzero = 0; result 0x10.
- Backpressure: hold rsp_ready = 0 for 5 cycles and drive a new req_valid → response stays stable, req_ready = 0, second request is not accepted until one cycle after the handshake.
- Assert rst during EXEC of a MUL → next cycle all outputs are 0 and state is IDLE; no response is ever produced. In the same cycle as an overflow capture, assert sticky_clr → sticky_ovf = 1.
